// File: rtl/serial_pkg.sv
// serial_pkg: receiver state encoding and line-level bit constants shared by the serial RX/TX blocks
package serial_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;
    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;
endpackage

// File: rtl/sipo_frame_rx_shift.sv
// sipo_shift: W-bit shift register filling from the MSB side so the first bit received lands in bit 0
module sipo_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         shift_en,
    input  logic         bit_in,
    output logic [W-1:0] data_out
);
    logic [W-1:0] data_d, data_q;
    always_comb data_d = clear ? '0 : shift_en ? {bit_in, data_q[W-1:1]} : data_q;
    always_ff @(posedge clk) data_q <= data_d;
    assign data_out = data_q;
endmodule

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: start/data/parity/stop frame deserialiser with a valid/ready parallel output
module sipo_frame_rx
    import serial_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_perr,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W);
    rx_state_t         state_d, state_q;
    logic [CW-1:0]     cnt_d, cnt_q;
    logic              perr_d, perr_q;
    logic [DATA_W-1:0] out_data_d, out_data_q;
    logic              out_valid_d, out_valid_q;
    logic              out_perr_d, out_perr_q;
    logic              frame_err_d, frame_err_q;
    logic              overrun_d, overrun_q;
    logic              shift_en, start_clr, load;
    logic [DATA_W-1:0] sh_data;
    sipo_shift #(.W(DATA_W)) u_shift (
        .clk      (clk),
        .clear    (reset || start_clr),
        .shift_en (shift_en),
        .bit_in   (serial_in),
        .data_out (sh_data)
    );
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        perr_d      = perr_q;
        shift_en    = 1'b0;
        start_clr   = 1'b0;
        load        = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        case (state_q)
            IDLE: if (serial_in == START_BIT) begin
                state_d   = DATA;
                cnt_d     = '0;
                perr_d    = 1'b0;
                start_clr = 1'b1;
            end
            DATA: begin
                shift_en = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(DATA_W - 1)) begin
                    cnt_d   = '0;
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                perr_d  = ^sh_data ^ serial_in ^ 1'(PARITY_ODD);
                state_d = STOP;
            end
            STOP: begin
                state_d = IDLE;
                // a 1 here is a broken frame, never a fresh start bit
                if (serial_in != STOP_BIT) frame_err_d = 1'b1;
                else if (!out_valid_q || out_ready) load = 1'b1;
                else overrun_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        out_data_d  = load ? sh_data : out_data_q;
        out_perr_d  = load ? perr_q : out_perr_q;
        out_valid_d = load || (out_valid_q && !out_ready);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            perr_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_perr_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            perr_q      <= perr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_perr_q  <= out_perr_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_perr  = out_perr_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = state_q != IDLE;
endmodule
